mem_bus_arbiter: RTL and testbench

- Shares the single C2 main-memory bus between two cache-side requesters (port 0: data cache, port 1: instruction cache).
- Each requester issues whole-line read/write transactions; the arbiter grants one requester at a time, forwards one command to memory, waits for the memory response, then returns data and a one-cycle response pulse.
- Sits between the cache instances and the memory model.

---
 rtl/mem_bus_arbiter_if.sv | 46 ++++
 rtl/mem_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle linking the two cache requesters, the arbiter and the memory model.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_bus_arbiter_if #(
  parameter int MEM_ADDR_SIZE   = 19,
  parameter int CACHE_LINE_SIZE = 16
);
  localparam int LINE_W = CACHE_LINE_SIZE * 8;

  logic [MEM_ADDR_SIZE-1:0] req0_addr;
  logic [1:0]               req0_cmd;
  logic [LINE_W-1:0]        req0_wdata;
  logic [LINE_W-1:0]        req0_rdata;
  logic                     req0_resp;
  logic                     req0_err;

  logic [MEM_ADDR_SIZE-1:0] req1_addr;
  logic [1:0]               req1_cmd;
  logic [LINE_W-1:0]        req1_wdata;
  logic [LINE_W-1:0]        req1_rdata;
  logic                     req1_resp;
  logic                     req1_err;

  logic [MEM_ADDR_SIZE-1:0] mem_addr;
  logic [1:0]               mem_cmd;
  logic [LINE_W-1:0]        mem_wdata;
  logic [LINE_W-1:0]        mem_rdata;
  logic                     mem_resp;

  modport slave (
    input  req0_addr, req0_cmd, req0_wdata,
    input  req1_addr, req1_cmd, req1_wdata,
    input  mem_rdata, mem_resp,
    output req0_rdata, req0_resp, req0_err,
    output req1_rdata, req1_resp, req1_err,
    output mem_addr, mem_cmd, mem_wdata
  );

  modport master (
    output req0_addr, req0_cmd, req0_wdata,
    output req1_addr, req1_cmd, req1_wdata,
    output mem_rdata, mem_resp,
    input  req0_rdata, req0_resp, req0_err,
    input  req1_rdata, req1_resp, req1_err,
    input  mem_addr, mem_cmd, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the C2 memory bus between data and instruction caches.
// Define MEM_BUS_ARBITER_TIMEOUT_EN to enable the WAIT-state watchdog.
module mem_bus_arbiter #(
  parameter int MEM_ADDR_SIZE   = 19,
  parameter int CACHE_LINE_SIZE = 16,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_bus_arbiter_if.slave bus
);
  localparam int         LINE_W   = CACHE_LINE_SIZE * 8;
  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_READ = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic                     rr_r;
  logic                     grant_r;
  logic                     rd_r;
  logic [MEM_ADDR_SIZE-1:0] mem_addr_r;
  logic [1:0]               mem_cmd_r;
  logic [LINE_W-1:0]        mem_wdata_r;
  logic [LINE_W-1:0]        req0_rdata_r;
  logic [LINE_W-1:0]        req1_rdata_r;
  logic                     req0_resp_r;
  logic                     req1_resp_r;
  logic                     req0_err_r;
  logic                     req1_err_r;
  logic                     req0_v_s;
  logic                     req1_v_s;
  logic                     sel_s;
  logic                     tmo_s;
  logic                     done_s;
  logic [LINE_W-1:0]        rsp_data_s;

  // Commands 2 and 3 are the only real requests, so bit 1 marks a valid request.
  assign req0_v_s   = bus.req0_cmd[1];
  assign req1_v_s   = bus.req1_cmd[1];
  assign sel_s      = (req0_v_s && req1_v_s) ? rr_r : req1_v_s;
  assign done_s     = (state_r == ST_WAIT) && (bus.mem_resp || tmo_s);
  assign rsp_data_s = (bus.mem_resp && rd_r) ? bus.mem_rdata : {LINE_W{1'b0}};

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST_C = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wdog_r;

  // Watchdog: cleared on the edge entering WAIT, advanced on every WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_r <= 8'd0;
    end else if (state_r == ST_ISSUE) begin
      wdog_r <= 8'd0;
    end else if (state_r == ST_WAIT) begin
      wdog_r <= wdog_r + 8'd1;
    end
  end

  // A real response on the expiry edge takes priority over the timeout.
  assign tmo_s = (state_r == ST_WAIT) && !bus.mem_resp && (wdog_r == TMO_LAST_C);
`else
  localparam int TIMEOUT_UNUSED_C = TIMEOUT_CYCLES;
  assign tmo_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req0_v_s || req1_v_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (done_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Grant capture, memory command forwarding and requester response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_r         <= 1'b0;
      grant_r      <= 1'b0;
      rd_r         <= 1'b0;
      mem_addr_r   <= {MEM_ADDR_SIZE{1'b0}};
      mem_cmd_r    <= CMD_NOP;
      mem_wdata_r  <= {LINE_W{1'b0}};
      req0_rdata_r <= {LINE_W{1'b0}};
      req1_rdata_r <= {LINE_W{1'b0}};
      req0_resp_r  <= 1'b0;
      req1_resp_r  <= 1'b0;
      req0_err_r   <= 1'b0;
      req1_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req0_v_s || req1_v_s) begin
            grant_r     <= sel_s;
            mem_addr_r  <= sel_s ? bus.req1_addr  : bus.req0_addr;
            mem_cmd_r   <= sel_s ? bus.req1_cmd   : bus.req0_cmd;
            mem_wdata_r <= sel_s ? bus.req1_wdata : bus.req0_wdata;
            rd_r        <= (sel_s ? bus.req1_cmd : bus.req0_cmd) == CMD_READ;
          end
        end
        ST_ISSUE: mem_cmd_r <= CMD_NOP;
        ST_WAIT: begin
          if (done_s && grant_r) begin
            req1_rdata_r <= rsp_data_s;
            req1_resp_r  <= 1'b1;
            req1_err_r   <= tmo_s;
          end else if (done_s) begin
            req0_rdata_r <= rsp_data_s;
            req0_resp_r  <= 1'b1;
            req0_err_r   <= tmo_s;
          end
        end
        ST_RESP: begin
          req0_resp_r <= 1'b0;
          req1_resp_r <= 1'b0;
          req0_err_r  <= 1'b0;
          req1_err_r  <= 1'b0;
          rr_r        <= ~grant_r;
        end
        default: mem_cmd_r <= CMD_NOP;
      endcase
    end
  end

  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_cmd    = mem_cmd_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.req0_rdata = req0_rdata_r;
  assign bus.req0_resp  = req0_resp_r;
  assign bus.req0_err   = req0_err_r;
  assign bus.req1_rdata = req1_rdata_r;
  assign bus.req1_resp  = req1_resp_r;
  assign bus.req1_err   = req1_err_r;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter: reset, read, round-robin ties,
// spurious responses, reset mid-transaction and (optionally) the watchdog.
module tb_mem_bus_arbiter;
  localparam int AW = 19;
  localparam int CL = 16;
  localparam int LW = CL * 8;
  localparam logic [LW-1:0] DAT_A5 = {16{8'hA5}};
  localparam logic [LW-1:0] DAT_R1 = {8{16'hC3C3}};
  localparam logic [LW-1:0] DAT_R2 = {4{32'h1234_5678}};
  localparam logic [LW-1:0] DAT_W0 = {4{32'hDEAD_BEEF}};
  localparam logic [LW-1:0] DAT_BAD = {4{32'hBAD0_BAD0}};
  localparam logic [LW-1:0] DAT_OK = {4{32'h0F0F_0F0F}};

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_bus_arbiter_if #(.MEM_ADDR_SIZE(AW), .CACHE_LINE_SIZE(CL)) bus ();

  mem_bus_arbiter #(
    .MEM_ADDR_SIZE(AW), .CACHE_LINE_SIZE(CL), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req0_cmd = 2'd2; bus.req0_addr = 19'h12345; bus.req0_wdata = DAT_W0;
    bus.req1_cmd = 2'd3; bus.req1_addr = 19'h00FF0; bus.req1_wdata = DAT_W0;
    bus.mem_resp = 1'b1; bus.mem_rdata = DAT_BAD;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.mem_cmd, bus.mem_addr, bus.req0_resp, bus.req1_resp, bus.req0_err, bus.req1_err} !== 25'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got cmd=%0d addr=%h r0=%b r1=%b want all 0", bus.mem_cmd, bus.mem_addr, bus.req0_resp, bus.req1_resp);
    end
    n_tests++;
    if ({bus.mem_wdata, bus.req0_rdata, bus.req1_rdata} !== {(3*LW){1'b0}}) begin
      n_fail++; $display("FAIL reset_data: got wdata=%h rd0=%h rd1=%h want 0", bus.mem_wdata, bus.req0_rdata, bus.req1_rdata);
    end
    bus.req0_cmd = 2'd0; bus.req1_cmd = 2'd0; bus.mem_resp = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.mem_cmd, bus.req0_resp, bus.req1_resp} !== 4'd0) begin
      n_fail++; $display("FAIL reset_idle: got cmd=%0d r0=%b r1=%b want 0", bus.mem_cmd, bus.req0_resp, bus.req1_resp);
    end
  endtask

  task automatic test_read();
    bus.req0_cmd = 2'd2; bus.req0_addr = 19'h00120;
    @(negedge clk);
    n_tests++;
    if (bus.mem_cmd !== 2'd2 || bus.mem_addr !== 19'h00120) begin
      n_fail++; $display("FAIL read_issue: got cmd=%0d addr=%h want 2 00120", bus.mem_cmd, bus.mem_addr);
    end
    @(negedge clk);
    n_tests++;
    if (bus.mem_cmd !== 2'd0 || bus.mem_addr !== 19'h00120) begin
      n_fail++; $display("FAIL read_cmd_1cyc: got cmd=%0d addr=%h want 0 00120", bus.mem_cmd, bus.mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.req0_resp !== 1'b0) begin
      n_fail++; $display("FAIL read_early_resp: got %b want 0", bus.req0_resp);
    end
    bus.mem_resp = 1'b1; bus.mem_rdata = DAT_A5;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    n_tests++;
    if (bus.req0_resp !== 1'b1 || bus.req0_rdata !== DAT_A5 || bus.req1_resp !== 1'b0) begin
      n_fail++; $display("FAIL read_resp: got r0=%b r1=%b rdata=%h want 1 0 %h", bus.req0_resp, bus.req1_resp, bus.req0_rdata, DAT_A5);
    end
    bus.req0_cmd = 2'd0;
    @(negedge clk);
    n_tests++;
    if (bus.req0_resp !== 1'b0 || bus.req0_rdata !== DAT_A5) begin
      n_fail++; $display("FAIL read_pulse_hold: got r0=%b rdata=%h want 0 %h", bus.req0_resp, bus.req0_rdata, DAT_A5);
    end
  endtask

  // req0 writes and req1 reads, both raised together; first names the expected winner.
  task automatic test_tie(input logic first, input logic [LW-1:0] rd);
    logic who;
    bus.req0_cmd = 2'd3; bus.req0_addr = 19'h00300; bus.req0_wdata = DAT_W0;
    bus.req1_cmd = 2'd2; bus.req1_addr = 19'h00440;
    for (int k = 0; k < 2; k++) begin
      who = (k == 0) ? first : ~first;
      @(negedge clk);
      n_tests++;
      if (bus.mem_cmd !== (who ? 2'd2 : 2'd3) || bus.mem_addr !== (who ? 19'h00440 : 19'h00300)) begin
        n_fail++; $display("FAIL tie_grant%0d: got cmd=%0d addr=%h want requester %0d", k, bus.mem_cmd, bus.mem_addr, who);
      end
      if (!who) begin
        n_tests++;
        if (bus.mem_wdata !== DAT_W0) begin
          n_fail++; $display("FAIL tie_wdata: got %h want %h", bus.mem_wdata, DAT_W0);
        end
      end
      @(negedge clk);
      n_tests++;
      if (bus.mem_cmd !== 2'd0) begin
        n_fail++; $display("FAIL tie_nop%0d: got cmd=%0d want 0", k, bus.mem_cmd);
      end
      bus.mem_resp = 1'b1; bus.mem_rdata = rd;
      @(negedge clk);
      bus.mem_resp = 1'b0;
      n_tests++;
      if ({bus.req1_resp, bus.req0_resp} !== (who ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL tie_resp%0d: got r1r0=%b%b want requester %0d", k, bus.req1_resp, bus.req0_resp, who);
      end
      n_tests++;
      if ((who ? bus.req1_rdata : bus.req0_rdata) !== (who ? rd : {LW{1'b0}})) begin
        n_fail++; $display("FAIL tie_rdata%0d: got rd0=%h rd1=%h", k, bus.req0_rdata, bus.req1_rdata);
      end
      if (who) bus.req1_cmd = 2'd0;
      else     bus.req0_cmd = 2'd0;
      @(negedge clk);
      n_tests++;
      if ({bus.req1_resp, bus.req0_resp} !== 2'b00) begin
        n_fail++; $display("FAIL tie_pulse%0d: got r1r0=%b%b want 00", k, bus.req1_resp, bus.req0_resp);
      end
    end
  endtask

  task automatic test_spurious();
    int pulses;
    bus.mem_resp = 1'b1; bus.mem_rdata = DAT_BAD;
    @(negedge clk);
    n_tests++;
    if ({bus.mem_cmd, bus.req0_resp, bus.req1_resp} !== 4'd0) begin
      n_fail++; $display("FAIL spur_idle: got cmd=%0d r0=%b r1=%b want 0", bus.mem_cmd, bus.req0_resp, bus.req1_resp);
    end
    bus.mem_resp = 1'b0;
    bus.req1_cmd = 2'd2; bus.req1_addr = 19'h07FF0;
    @(negedge clk);
    n_tests++;
    if (bus.mem_cmd !== 2'd2 || bus.mem_addr !== 19'h07FF0) begin
      n_fail++; $display("FAIL spur_issue: got cmd=%0d addr=%h want 2 07ff0", bus.mem_cmd, bus.mem_addr);
    end
    bus.mem_resp = 1'b1;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    n_tests++;
    if (bus.req1_resp !== 1'b0) begin
      n_fail++; $display("FAIL spur_issue_resp: got %b want 0", bus.req1_resp);
    end
    @(negedge clk);
    bus.mem_resp = 1'b1; bus.mem_rdata = DAT_R2;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    n_tests++;
    if (bus.req1_resp !== 1'b1 || bus.req1_rdata !== DAT_R2) begin
      n_fail++; $display("FAIL spur_real: got r1=%b rdata=%h want 1 %h", bus.req1_resp, bus.req1_rdata, DAT_R2);
    end
    bus.req1_cmd = 2'd0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.req0_resp || bus.req1_resp) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL spur_extra: got %0d extra pulses want 0", pulses);
    end
  endtask

  task automatic test_reset_wait();
    int pulses;
    bus.req0_cmd = 2'd2; bus.req0_addr = 19'h00A00;
    @(negedge clk);
    n_tests++;
    if (bus.mem_cmd !== 2'd2) begin
      n_fail++; $display("FAIL rstw_issue: got cmd=%0d want 2", bus.mem_cmd);
    end
    @(negedge clk);
    rst_n = 1'b0; bus.req0_cmd = 2'd0;
    @(negedge clk);
    n_tests++;
    if ({bus.mem_cmd, bus.mem_addr, bus.req0_resp, bus.req0_rdata} !== {(2 + AW + 1 + LW){1'b0}}) begin
      n_fail++; $display("FAIL rstw_abort: got cmd=%0d addr=%h r0=%b rd0=%h want 0", bus.mem_cmd, bus.mem_addr, bus.req0_resp, bus.req0_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_resp = 1'b1; bus.mem_rdata = DAT_BAD;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.req0_resp || bus.req1_resp) pulses++;
    end
    n_tests++;
    if (pulses !== 0 || bus.req0_rdata !== {LW{1'b0}}) begin
      n_fail++; $display("FAIL rstw_late: got pulses=%0d rd0=%h want 0 0", pulses, bus.req0_rdata);
    end
    bus.req1_cmd = 2'd2; bus.req1_addr = 19'h00B40;
    @(negedge clk);
    n_tests++;
    if (bus.mem_cmd !== 2'd2 || bus.mem_addr !== 19'h00B40) begin
      n_fail++; $display("FAIL rstw_next_issue: got cmd=%0d addr=%h want 2 00b40", bus.mem_cmd, bus.mem_addr);
    end
    @(negedge clk);
    bus.mem_resp = 1'b1; bus.mem_rdata = DAT_OK;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    n_tests++;
    if (bus.req1_resp !== 1'b1 || bus.req1_rdata !== DAT_OK) begin
      n_fail++; $display("FAIL rstw_next_resp: got r1=%b rdata=%h want 1 %h", bus.req1_resp, bus.req1_rdata, DAT_OK);
    end
    bus.req1_cmd = 2'd0;
    @(negedge clk);
  endtask

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    bus.req1_cmd = 2'd2; bus.req1_addr = 19'h01230;
    @(negedge clk);
    n_tests++;
    if (bus.mem_cmd !== 2'd2) begin
      n_fail++; $display("FAIL tmo_issue: got cmd=%0d want 2", bus.mem_cmd);
    end
    early = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.req1_resp) early++;
    end
    n_tests++;
    if (early !== 0) begin
      n_fail++; $display("FAIL tmo_early: got %0d early resp cycles want 0", early);
    end
    @(negedge clk);
    n_tests++;
    if (bus.req1_resp !== 1'b1 || bus.req1_err !== 1'b1 || bus.req1_rdata !== {LW{1'b0}}) begin
      n_fail++; $display("FAIL tmo_fire: got r1=%b err=%b rdata=%h want 1 1 0", bus.req1_resp, bus.req1_err, bus.req1_rdata);
    end
    bus.req1_cmd = 2'd0;
    @(negedge clk);
    n_tests++;
    if (bus.req1_resp !== 1'b0 || bus.req1_err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_clear: got r1=%b err=%b want 0 0", bus.req1_resp, bus.req1_err);
    end
    bus.req0_cmd = 2'd2; bus.req0_addr = 19'h00040;
    @(negedge clk);
    @(negedge clk);
    bus.mem_resp = 1'b1; bus.mem_rdata = DAT_R1;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    n_tests++;
    if (bus.req0_resp !== 1'b1 || bus.req0_err !== 1'b0 || bus.req0_rdata !== DAT_R1) begin
      n_fail++; $display("FAIL tmo_recover: got r0=%b err=%b rdata=%h want 1 0 %h", bus.req0_resp, bus.req0_err, bus.req0_rdata, DAT_R1);
    end
    bus.req0_cmd = 2'd0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_tie(1'b0, DAT_R1);
    test_read();
    test_tie(1'b1, DAT_R2);
    test_spurious();
    test_reset_wait();
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
